// File: rtl/accumulator_sequencer_if.sv
// Command channel between the host FSM and the accumulator sequencer.
// The host drives the master side and the sequencer sits on the slave side.
interface accumulator_sequencer_if #(
  parameter int N  = 4,
  parameter int RW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [N-1:0]  cmd_operand;
  logic [RW-1:0] cmd_repeat;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_operand,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_operand,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/accumulator_sequencer.sv
// Sequences one {op, operand, repeat} command onto the accumulator datapath:
// load B, apply op (repeat+1) times, then report A with a single-cycle done pulse.
//
//   state | meaning
//   IDLE  | ready for a command, ALU held, acc_data keeps the last operand
//   LOAD  | operand on acc_data, ALU held, B captures operand
//   EXEC  | op on acc_alu_ctrl, A updates every cycle, count runs down to zero
//   WB    | ALU held, done high, A is final and captured into result
module accumulator_sequencer #(
  parameter int         N         = 4,
  parameter int         RW        = 3,
  parameter logic [3:0] HOLD_CODE = 4'b0000
) (
  input  logic                          clock,
  input  logic                          reset,
  accumulator_sequencer_if.slave        cmd,
  output logic [N-1:0]                  acc_data,
  output logic [3:0]                    acc_alu_ctrl,
  input  logic [N-1:0]                  acc_result,
  output logic                          busy,
  output logic                          done,
  output logic [N-1:0]                  result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [N-1:0]  operand_q;
  logic [RW-1:0] count;

  // Ready is a decode of the state register, so it cannot coincide with done (WB).
  assign cmd.cmd_ready = (state == IDLE);

  // Outputs are loaded with the value for the state being entered, so they
  // change only on clock edges and stay stable for the whole cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      operand_q    <= '0;
      count        <= '0;
      acc_data     <= '0;
      acc_alu_ctrl <= HOLD_CODE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc_alu_ctrl <= HOLD_CODE;
          done         <= 1'b0;
          if (cmd.cmd_valid) begin
            op_q      <= cmd.cmd_op;
            operand_q <= cmd.cmd_operand;
            count     <= cmd.cmd_repeat;
            acc_data  <= cmd.cmd_operand;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          acc_alu_ctrl <= op_q;
          state        <= EXEC;
        end
        EXEC: begin
          if (count == '0) begin
            acc_alu_ctrl <= HOLD_CODE;
            done         <= 1'b1;
            state        <= WB;
          end else begin
            count <= count - 1'b1;
          end
        end
        WB: begin
          result <= acc_result;
          done   <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          acc_alu_ctrl <= HOLD_CODE;
          done         <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Sequencer driving a small accumulator model (0=hold A, 1=pass B, 2=A+B, 3=A-B).
module tb_accumulator_sequencer;

  localparam int N  = 4;
  localparam int RW = 3;
  localparam logic [3:0] HOLD = 4'b0000;

  logic         clock;
  logic         reset;
  logic [N-1:0] acc_data;
  logic [3:0]   acc_alu_ctrl;
  logic [N-1:0] acc_result;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  accumulator_sequencer_if #(.N(N), .RW(RW)) cmd_if ();

  accumulator_sequencer #(.N(N), .RW(RW), .HOLD_CODE(HOLD)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd          (cmd_if.slave),
    .acc_data     (acc_data),
    .acc_alu_ctrl (acc_alu_ctrl),
    .acc_result   (acc_result),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  // Accumulator: B follows acc_data every cycle, A takes the ALU output.
  logic [N-1:0] reg_a, reg_b, alu_out;
  always_comb begin
    alu_out = reg_a;
    case (acc_alu_ctrl)
      4'd1:    alu_out = reg_b;
      4'd2:    alu_out = reg_a + reg_b;
      4'd3:    alu_out = reg_a - reg_b;
      default: alu_out = reg_a;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      reg_a <= alu_out;
      reg_b <= acc_data;
    end
  end
  assign acc_result = reg_a;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // In IDLE and WB the ALU must be held, and done never overlaps ready.
  always @(negedge clock) begin
    if (!reset && (cmd_if.cmd_ready || done)) begin
      check("hold_idle_wb", int'(acc_alu_ctrl), int'(HOLD));
      check("ready_done_excl", int'(cmd_if.cmd_ready && done), 0);
    end
  end

  task automatic run_cmd(input logic [3:0] op, input logic [3:0] operand,
                         input logic [2:0] rep, input logic [3:0] exp_res);
    int w;
    int last;
    @(negedge clock);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = op;
    cmd_if.cmd_operand = operand;
    cmd_if.cmd_repeat  = rep;
    w = 0;
    while (!cmd_if.cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("ready_wait", int'(w < 50), 1);
    @(posedge clock);
    #1;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_operand = ~operand;
    cmd_if.cmd_op      = 4'hE;
    cmd_if.cmd_repeat  = 3'd7;
    last = 3 + int'(rep);
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      check("busy", int'(busy), 1);
      check("ready_low", int'(cmd_if.cmd_ready), 0);
      check("done_timing", int'(done), int'(k == last));
      if (k < last) check("acc_data", int'(acc_data), int'(operand));
      if (k == 1 || k == last) check("ctrl_hold", int'(acc_alu_ctrl), int'(HOLD));
      else check("ctrl_op", int'(acc_alu_ctrl), int'(op));
    end
    @(negedge clock);
    check("done_pulse_end", int'(done), 0);
    check("ready_back", int'(cmd_if.cmd_ready), 1);
    check("busy_end", int'(busy), 0);
    check("result", int'(result), int'(exp_res));
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] operand;
    logic [2:0] rep;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dones;
    vecs[0] = '{4'd1, 4'h9, 3'd0, 4'h9};
    vecs[1] = '{4'd2, 4'h3, 3'd0, 4'hC};
    vecs[2] = '{4'd1, 4'h1, 3'd0, 4'h1};
    vecs[3] = '{4'd2, 4'h3, 3'd7, 4'h9};
    vecs[4] = '{4'd1, 4'h2, 3'd0, 4'h2};
    vecs[5] = '{4'd3, 4'h5, 3'd0, 4'hD};
    vecs[6] = '{4'd2, 4'hF, 3'd1, 4'hB};
    vecs[7] = '{4'd7, 4'h4, 3'd2, 4'hB};

    reset = 1'b1;
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_op      = 4'd0;
    cmd_if.cmd_operand = 4'd0;
    cmd_if.cmd_repeat  = 3'd0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_ctrl", int'(acc_alu_ctrl), int'(HOLD));
    check("rst_data", int'(acc_data), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) run_cmd(vecs[i].op, vecs[i].operand, vecs[i].rep, vecs[i].exp_res);

    // valid held high: one command every 4 cycles, +1 each time from A=B
    @(negedge clock);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = 4'd2;
    cmd_if.cmd_operand = 4'h1;
    cmd_if.cmd_repeat  = 3'd0;
    dones = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    cmd_if.cmd_valid = 1'b0;
    check("b2b_done_count", dones, 4);
    @(negedge clock);
    check("b2b_result", int'(result), 4'hF);
    check("b2b_idle", int'(busy), 0);

    // reset in the middle of EXEC
    @(negedge clock);
    cmd_if.cmd_valid   = 1'b1;
    cmd_if.cmd_op      = 4'd2;
    cmd_if.cmd_operand = 4'h3;
    cmd_if.cmd_repeat  = 3'd5;
    @(posedge clock);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_ctrl", int'(acc_alu_ctrl), 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ctrl", int'(acc_alu_ctrl), int'(HOLD));
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_a", int'(reg_a), 0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done || busy) dones++;
    end
    check("no_done_after_abort", dones, 0);
    run_cmd(4'd2, 4'h4, 3'd0, 4'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
